// File: rtl/uart_modem_dce_if.sv
// Modem-control line bundle between a DTE (master) and the DCE modem model (slave).
interface uart_modem_dce_if;
  logic rts_n;
  logic dtr_n;
  logic cts_n;
  logic dsr_n;
  logic ri_n;
  logic cd_n;

  modport master (output rts_n, dtr_n, input cts_n, dsr_n, ri_n, cd_n);
  modport slave  (input rts_n, dtr_n, output cts_n, dsr_n, ri_n, cd_n);
endinterface

// File: rtl/uart_modem_dce.sv
// DCE modem model: ring cadence, answer on DTR, CTS turnaround, hang-up events.
// Optional: define UART_MODEM_DCE_DTR_HANGUP_EN to hang up on a sustained DTR drop.
module uart_modem_dce #(
  parameter int NrSyncStages   = 2,
  parameter int CntWidth       = 16,
  parameter int RingOnCycles   = 1000,
  parameter int RingOffCycles  = 3000,
  parameter int MaxRings       = 4,
  parameter int CtsDelayCycles = 8,
  parameter int DtrDropCycles  = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  uart_modem_dce_if.slave  mdm,
  input  logic             dsr_en_i,
  input  logic             call_req_i,
  input  logic             hangup_i,
  output logic [1:0]       state_o,
  output logic             event_valid_o,
  output logic [1:0]       event_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, RING_ON = 2'd1, RING_OFF = 2'd2, CONNECTED = 2'd3} state_e;
  typedef enum logic [1:0] {EV_ANSWERED = 2'd0, EV_MISSED = 2'd1, EV_HUP_DTR = 2'd2, EV_HUP_LOCAL = 2'd3} event_e;

  localparam logic [CntWidth-1:0] RingOnLast  = CntWidth'(RingOnCycles - 1);
  localparam logic [CntWidth-1:0] RingOffLast = CntWidth'(RingOffCycles - 1);
  localparam logic [CntWidth-1:0] CtsDelay    = CntWidth'(CtsDelayCycles);

  logic [NrSyncStages-1:0] rts_sync_q, dtr_sync_q;
  logic rts_s, dtr_s;

  state_e state_q, state_d;
  event_e ev_q, ev_d;
  logic ev_vld_q, ev_vld_d;
  logic [CntWidth-1:0] timer_q, timer_d, cts_cnt_q, cts_cnt_d;
  logic [3:0] ring_cnt_q, ring_cnt_d;
  logic cts_n_q, dsr_n_q, ri_n_q, cd_n_q;
`ifdef UART_MODEM_DCE_DTR_HANGUP_EN
  localparam logic [CntWidth-1:0] DtrDropLast = CntWidth'(DtrDropCycles - 1);
  logic [CntWidth-1:0] dtr_cnt_q, dtr_cnt_d;
`endif

  // Synchroniser flops idle at 1 so a reset looks like an inactive DTE.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rts_sync_q <= '1;
      dtr_sync_q <= '1;
    end else begin
      rts_sync_q[0] <= mdm.rts_n;
      dtr_sync_q[0] <= mdm.dtr_n;
      for (int i = 1; i < NrSyncStages; i++) begin
        rts_sync_q[i] <= rts_sync_q[i-1];
        dtr_sync_q[i] <= dtr_sync_q[i-1];
      end
    end
  end

  assign rts_s = ~rts_sync_q[NrSyncStages-1];
  assign dtr_s = ~dtr_sync_q[NrSyncStages-1];

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    ring_cnt_d = ring_cnt_q;
    cts_cnt_d  = '0;
    ev_vld_d   = 1'b0;
    ev_d       = ev_q;
`ifdef UART_MODEM_DCE_DTR_HANGUP_EN
    dtr_cnt_d  = '0;
`endif
    unique case (state_q)
      IDLE: if (call_req_i) state_d = RING_ON;
      RING_ON, RING_OFF: begin
        // Local hang-up beats answer, answer beats a missed-call timeout.
        if (hangup_i) begin
          state_d = IDLE; ev_vld_d = 1'b1; ev_d = EV_HUP_LOCAL;
        end else if (dtr_s) begin
          state_d = CONNECTED; ev_vld_d = 1'b1; ev_d = EV_ANSWERED;
        end else if (state_q == RING_ON) begin
          if (timer_q == RingOnLast) state_d = RING_OFF;
          else timer_d = timer_q + 1'b1;
        end else if (timer_q == RingOffLast) begin
          if (ring_cnt_q + 4'd1 == 4'(MaxRings)) begin
            state_d = IDLE; ev_vld_d = 1'b1; ev_d = EV_MISSED;
          end else begin
            state_d = RING_ON; ring_cnt_d = ring_cnt_q + 4'd1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      CONNECTED: begin
        if (rts_s) cts_cnt_d = (cts_cnt_q == '1) ? cts_cnt_q : cts_cnt_q + 1'b1;
`ifdef UART_MODEM_DCE_DTR_HANGUP_EN
        if (!dtr_s) dtr_cnt_d = (dtr_cnt_q == '1) ? dtr_cnt_q : dtr_cnt_q + 1'b1;
`endif
        if (hangup_i) begin
          state_d = IDLE; ev_vld_d = 1'b1; ev_d = EV_HUP_LOCAL;
`ifdef UART_MODEM_DCE_DTR_HANGUP_EN
        end else if (!dtr_s && dtr_cnt_q == DtrDropLast) begin
          state_d = IDLE; ev_vld_d = 1'b1; ev_d = EV_HUP_DTR;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      timer_d   = '0;
      cts_cnt_d = '0;
`ifdef UART_MODEM_DCE_DTR_HANGUP_EN
      dtr_cnt_d = '0;
`endif
      if (state_d == IDLE || state_d == CONNECTED) ring_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ev_q       <= EV_ANSWERED;
      ev_vld_q   <= 1'b0;
      timer_q    <= '0;
      cts_cnt_q  <= '0;
      ring_cnt_q <= '0;
      cts_n_q    <= 1'b1;
      dsr_n_q    <= 1'b1;
      ri_n_q     <= 1'b1;
      cd_n_q     <= 1'b1;
`ifdef UART_MODEM_DCE_DTR_HANGUP_EN
      dtr_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ev_q       <= ev_d;
      ev_vld_q   <= ev_vld_d;
      timer_q    <= timer_d;
      cts_cnt_q  <= cts_cnt_d;
      ring_cnt_q <= ring_cnt_d;
      // CTS only while staying connected and RTS has been held long enough.
      cts_n_q    <= ~(state_q == CONNECTED && state_d == CONNECTED && rts_s && cts_cnt_q >= CtsDelay);
      dsr_n_q    <= ~dsr_en_i;
      ri_n_q     <= (state_d != RING_ON);
      cd_n_q     <= (state_d != CONNECTED);
`ifdef UART_MODEM_DCE_DTR_HANGUP_EN
      dtr_cnt_q  <= dtr_cnt_d;
`endif
    end
  end

  assign mdm.cts_n     = cts_n_q;
  assign mdm.dsr_n     = dsr_n_q;
  assign mdm.ri_n      = ri_n_q;
  assign mdm.cd_n      = cd_n_q;
  assign state_o       = state_q;
  assign event_valid_o = ev_vld_q;
  assign event_o       = ev_q;
endmodule

// File: tb/tb_uart_modem_dce.sv
// Randomised + directed bench for uart_modem_dce against a call-timeline model.
module tb_uart_modem_dce;
  localparam int NS = 2, CW = 16, RON = 4, ROFF = 6, MR = 2, CTSD = 8, DTRD = 16;
  localparam int P = RON + ROFF;

  logic clk = 1'b0;
  logic rst_n, dsr_en, call_req, hangup;
  logic [1:0] d_state, d_ev;
  logic d_evv;

  uart_modem_dce_if mif();

  uart_modem_dce #(
    .NrSyncStages(NS), .CntWidth(CW), .RingOnCycles(RON), .RingOffCycles(ROFF),
    .MaxRings(MR), .CtsDelayCycles(CTSD), .DtrDropCycles(DTRD)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .mdm(mif), .dsr_en_i(dsr_en), .call_req_i(call_req),
    .hangup_i(hangup), .state_o(d_state), .event_valid_o(d_evv), .event_o(d_ev)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int n_ev_exp = 0, n_ev_dut = 0;
  bit chk_en = 0;

  // Model: call status 0 idle / 1 ringing / 2 connected, t = cycles since ringing began.
  int m_st = 0, m_t = 0, m_run = 0, m_dlow = 0;
  int exp_cts = 1, exp_dsr = 1, exp_ri = 1, exp_cd = 1, exp_state = 0, exp_evv = 0, exp_ev = 0;
  bit rts_h [NS];
  bit dtr_h [NS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit rts_s, dtr_s;
    int nst, ev;
    rts_s = !rts_h[NS-1];
    dtr_s = !dtr_h[NS-1];
    exp_cts = 1;
    if (!rst_n) begin
      m_st = 0; m_t = 0; m_run = 0; m_dlow = 0;
      exp_evv = 0; exp_ev = 0; exp_dsr = 1;
      for (int i = 0; i < NS; i++) begin rts_h[i] = 1'b1; dtr_h[i] = 1'b1; end
    end else begin
      ev = -1; nst = m_st;
      case (m_st)
        0: if (call_req) begin nst = 1; m_t = 0; end
        1: begin
          if (hangup) begin nst = 0; ev = 3; end
          else if (dtr_s) begin nst = 2; ev = 0; end
          else if (m_t + 1 == MR * P) begin nst = 0; ev = 1; end
          else m_t++;
        end
        default: begin
          if (hangup) begin nst = 0; ev = 3; end
`ifdef UART_MODEM_DCE_DTR_HANGUP_EN
          else if (!dtr_s && m_dlow + 1 >= DTRD) begin nst = 0; ev = 2; end
`endif
          m_dlow = dtr_s ? 0 : m_dlow + 1;
          m_run  = rts_s ? m_run + 1 : 0;
          if (nst == 2 && m_run > CTSD) exp_cts = 0;
        end
      endcase
      if (nst != m_st) begin m_run = 0; m_dlow = 0; end
      m_st = nst;
      exp_evv = (ev >= 0);
      if (ev >= 0) begin exp_ev = ev; n_ev_exp++; end
      exp_dsr = !dsr_en;
      for (int i = NS - 1; i > 0; i--) begin rts_h[i] = rts_h[i-1]; dtr_h[i] = dtr_h[i-1]; end
      rts_h[0] = mif.rts_n;
      dtr_h[0] = mif.dtr_n;
    end
    exp_state = (m_st == 0) ? 0 : (m_st == 2) ? 3 : (((m_t % P) < RON) ? 1 : 2);
    exp_ri = (exp_state == 1) ? 0 : 1;
    exp_cd = (m_st == 2) ? 0 : 1;
  endtask

  task automatic step();
    dsr_en = 1'($urandom_range(0, 1));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cts_n", mif.cts_n, exp_cts);
      chk("dsr_n", mif.dsr_n, exp_dsr);
      chk("ri_n", mif.ri_n, exp_ri);
      chk("cd_n", mif.cd_n, exp_cd);
      chk("state_o", d_state, exp_state);
      chk("event_valid_o", d_evv, exp_evv);
      if (exp_evv != 0) chk("event_o", d_ev, exp_ev);
      if (d_evv === 1'b1) n_ev_dut++;
    end
  end

  initial begin
    rst_n = 1'b0; dsr_en = 1'b0; call_req = 1'b0; hangup = 1'b0;
    mif.rts_n = 1'b1; mif.dtr_n = 1'b1;
    #1;
    step(); chk_en = 1;
    step(); step();
    chk("rst_state", d_state, 0);
    chk("rst_ri", mif.ri_n, 1);
    rst_n = 1'b1;

    // Reset in the middle of a ring
    call_req = 1; step(); call_req = 0;
    repeat (5) step();
    chk("midrst_ring_off", d_state, 2);
    rst_n = 1'b0; step();
    chk("midrst_state", d_state, 0);
    chk("midrst_evv", d_evv, 0);
    chk("midrst_cd", mif.cd_n, 1);
    step(); rst_n = 1'b1;
    repeat (12) step();
    chk("post_rst_ri", mif.ri_n, 1);

    // Missed call: two rings of 4 on / 6 off
    call_req = 1; step(); call_req = 0;
    chk("miss_ri_k0", mif.ri_n, 0);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 4)  chk("miss_ri_k4", mif.ri_n, 1);
      if (k == 10) chk("miss_ri_k10", mif.ri_n, 0);
      if (k == 19) chk("miss_state_k19", d_state, 2);
      if (k == 20) begin
        chk("miss_state_k20", d_state, 0);
        chk("miss_evv", d_evv, 1);
        chk("miss_ev", d_ev, 1);
      end
    end
    chk("dsr_follow", mif.dsr_n, !dsr_en);

    // Answer during the second ring
    call_req = 1; step(); call_req = 0;
    repeat (10) step();
    mif.dtr_n = 0; step(); step();
    chk("ans_still_ringing", d_state, 1);
    step();
    chk("ans_state", d_state, 3);
    chk("ans_ri", mif.ri_n, 1);
    chk("ans_cd", mif.cd_n, 0);
    chk("ans_ev", d_ev, 0);

    // CTS turnaround
    mif.rts_n = 0;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 10) chk("cts_k10", mif.cts_n, 1);
      if (k == 11) chk("cts_k11", mif.cts_n, 0);
    end
    mif.rts_n = 1;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 2) chk("cts_rel_k2", mif.cts_n, 0);
      if (k == 3) chk("cts_rel_k3", mif.cts_n, 1);
    end
    mif.rts_n = 0;
    repeat (15) step();

    // DTR glitch vs sustained drop
    mif.dtr_n = 1; repeat (10) step(); mif.dtr_n = 0;
    repeat (5) step();
    chk("dtr_glitch_state", d_state, 3);
    mif.dtr_n = 1; repeat (16) step(); mif.dtr_n = 0;
    repeat (2) step();
`ifdef UART_MODEM_DCE_DTR_HANGUP_EN
    chk("dtr_drop_state", d_state, 0);
    chk("dtr_drop_ev", d_ev, 2);
    chk("dtr_drop_cts", mif.cts_n, 1);
`else
    chk("dtr_drop_ignored", d_state, 3);
    hangup = 1; step(); hangup = 0;
    chk("hup_state", d_state, 0);
    chk("hup_ev", d_ev, 3);
`endif
    mif.rts_n = 1;

    // Hang-up and answer on the same RING_OFF cycle
    mif.dtr_n = 1; repeat (3) step();
    call_req = 1; step(); call_req = 0;
    repeat (5) step();
    mif.dtr_n = 0; step(); step();
    hangup = 1; step(); hangup = 0;
    chk("prio_state", d_state, 0);
    chk("prio_ev", d_ev, 3);

    // call_req while connected is ignored
    call_req = 1; step(); call_req = 0;
    repeat (2) step();
    call_req = 1; step(); call_req = 0;
    step();
    chk("callreq_conn_state", d_state, 3);
    chk("callreq_conn_evv", d_evv, 0);
    hangup = 1; step(); hangup = 0;

    // Random traffic
    for (int c = 0; c < 700; c++) begin
      call_req = ($urandom_range(0, 19) == 0);
      hangup   = ($urandom_range(0, 59) == 0);
      rst_n    = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 7) == 0)  mif.rts_n = ~mif.rts_n;
      if ($urandom_range(0, 24) == 0) mif.dtr_n = ~mif.dtr_n;
      step();
    end
    call_req = 0; hangup = 0; rst_n = 1;
    step(); step();
    chk("event_count", n_ev_dut, n_ev_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_modem_dce.md
Name: uart_modem_dce

Overview:
DCE-side (modem-end) counterpart of the UART modem-control interface. It receives RTS/DTR from the DTE and drives CTS/DSR/RI/CD back. An internal call FSM generates the ring cadence, answers on DTR, and asserts carrier. It gates CTS from RTS with a programmable turnaround delay and hangs up on DTR drop or on a local request. It is used as a loopback/test peer for the UART and as a modem model in the chip testbench.

Parameters:
NrSyncStages, 2, flop stages on each of rts_n/dtr_n input synchronisers (>=1)
CntWidth, 16, width of all internal timing counters
RingOnCycles, 1000, cycles ri_n held low per ring (1..2^CntWidth-1)
RingOffCycles, 3000, cycles ri_n held high between rings (1..2^CntWidth-1)
MaxRings, 4, rings without answer before the call is dropped as missed (1..15)
CtsDelayCycles, 8, cycles from synchronised RTS assertion to CTS assertion (0..2^CntWidth-1)
DtrDropCycles, 16, consecutive cycles DTR must stay deasserted in CONNECTED before hang-up (1..2^CntWidth-1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
rts_n  in  1  DTE Ready To Send, active-low, asynchronous to clk_i
dtr_n  in  1  DTE Data Terminal Ready, active-low, asynchronous to clk_i
cts_n  out  1  Clear To Send, active-low, registered
dsr_n  out  1  Data Set Ready, active-low, registered
ri_n  out  1  Ring Indicator, active-low, registered
cd_n  out  1  Carrier Detect, active-low, registered
dsr_en_i  in  1  local "modem powered/ready"; drives DSR
call_req_i  in  1  single-cycle pulse: incoming call
hangup_i  in  1  single-cycle pulse: local hang-up
state_o  out  2  0 IDLE, 1 RING_ON, 2 RING_OFF, 3 CONNECTED
event_valid_o  out  1  single-cycle event strobe
event_o  out  2  0 ANSWERED, 1 MISSED, 2 HUP_DTR, 3 HUP_LOCAL; valid with event_valid_o

Behaviour:
- Reset (rst_ni=0 at a clock edge): cts_n=dsr_n=ri_n=cd_n=1; state_o=IDLE; event_valid_o=0; event_o=0; all counters 0; synchroniser flops =1 (inactive). Reset mid-call aborts immediately, with no event.
- Synchronisers: plain flop chains, synchronous reset. rts_s/dtr_s denote the active-high synchronised values.
- dsr_n <= ~dsr_en_i, with 1-cycle latency in all states.
- IDLE: ri_n=1, cd_n=1, cts_n=1. On call_req_i -> RING_ON, ring_cnt=0, timer=0. hangup_i is ignored.
- RING_ON: ri_n=0. After timer reaches RingOnCycles-1 -> RING_OFF, timer=0.
- RING_OFF: ri_n=1. After timer reaches RingOffCycles-1:
  - ring_cnt+1==MaxRings -> IDLE, emit MISSED;
  - else ring_cnt++ and -> RING_ON.
- Answer: dtr_s=1 on any cycle in RING_ON/RING_OFF -> CONNECTED next cycle, ri_n=1, emit ANSWERED. Answer has priority over MISSED on the same cycle.
- hangup_i in RING_ON/RING_OFF -> IDLE, emit HUP_LOCAL. This has priority over answer.
- CONNECTED:
  - cd_n=0.
  - CTS: while rts_s=1, cts_cnt counts up and saturates. cts_n=0 once cts_cnt>=CtsDelayCycles; delay 0 means cts_n follows rts_s with 1-cycle latency.
  - rts_s=0 -> cts_n=1 next cycle, cts_cnt=0.
- Hang-up from CONNECTED: hangup_i -> IDLE, emit HUP_LOCAL. DTR drop per Optional Feature, emitting HUP_DTR. Local hang-up wins if both occur on the same cycle.
- Leaving CONNECTED: cd_n=1 and cts_n=1 on the next cycle, all counters cleared.
- call_req_i outside IDLE is ignored.
- Events: exactly one event per call. The event is registered, so event_valid_o is high one cycle after the transition edge. state_o is registered with the state.
- Counters never wrap. Timers clear on every state change.

Optional Feature:
UART_MODEM_DCE_DTR_HANGUP_EN
- Defined: in CONNECTED, a dtr_cnt counts consecutive dtr_s=0 cycles and clears on dtr_s=1. When it reaches DtrDropCycles -> IDLE, emit HUP_DTR. Glitches shorter than DtrDropCycles are ignored.
- Undefined: DTR is ignored in CONNECTED, no dtr_cnt is built, and only hangup_i ends a call. HUP_DTR is never emitted.

Test Plan:
- Reset mid-operation (RingOnCycles=4, RingOffCycles=6): pulse call_req_i, then hold rst_ni=0 during RING_OFF -> all outputs 1, state_o=0, no event_valid_o; ri_n stays high afterwards.
- Missed call (RingOnCycles=4, RingOffCycles=6, MaxRings=2, dtr_n=1): pulse call_req_i -> ri_n low for 4 cycles and high for 6, twice. state_o returns to 0 at cycle 20 after entry. event_o=1 strobed once.
- Answer in second ring: dtr_n=0 during ring 2 RING_ON -> ri_n=1 and state_o=3 one cycle after dtr_s rises, cd_n=0, event_o=0 strobed.
- CTS turnaround (CtsDelayCycles=8, CONNECTED): rts_n 1->0 -> cts_n=0 exactly NrSyncStages+9 cycles later. rts_n 0->1 -> cts_n=1 NrSyncStages+1 cycles later.
- DTR glitch vs drop (macro defined, DtrDropCycles=16): dtr_n high 10 cycles -> stays CONNECTED. dtr_n high 16 cycles -> IDLE, cd_n=1, cts_n=1, event_o=2. With the macro undefined, the same stimulus stays CONNECTED.
- Priority: hangup_i and dtr answer on the same RING_OFF cycle -> IDLE with event_o=3. call_req_i in CONNECTED is ignored. dsr_en_i toggles -> dsr_n follows inverted with 1-cycle latency.
